// File: rtl/serial_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_ctrl_pkg
// Brief    : Shared types and constants for the serial frame controller:
//            top FSM states, sync detector states and sync pattern length.
// Revision : 1.0 - initial release
// ============================================================================
package serial_frame_ctrl_pkg;

  // Top-level frame FSM
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } fsm_state_t;

  // Sync pattern (1,0,1) detector states; name = bits seen so far
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_1    = 2'd1,
    S_10   = 2'd2,
    S_101  = 2'd3
  } sync_state_t;

  // Length of the sync pattern in bits
  localparam int SYNC_LEN = 3;

endpackage : serial_frame_ctrl_pkg
`default_nettype wire

// File: rtl/serial_frame_ctrl_sync_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_detect
// Brief    : Moore detector for the overlapping sync pattern 1,0,1 on din.
//            hit is high while in S_101. hit_next is the same decision one
//            sample early (S_10 with din=1), letting the frame FSM leave HUNT
//            on the very edge that samples the final sync bit.
// Revision : 1.0 - initial release
// ============================================================================
module sync_detect
  import serial_frame_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic din,
  output logic hit,
  output logic hit_next
);

  sync_state_t r_state;
  sync_state_t w_next;

  // Next-state decode; from S_101 the trailing bits are reused (overlap)
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = din ? S_1   : S_IDLE;
      S_1:     w_next = din ? S_1   : S_10;
      S_10:    w_next = din ? S_101 : S_IDLE;
      S_101:   w_next = din ? S_1   : S_10;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; clr holds the search at its start while a frame is received
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign hit      = (r_state == S_101);
  assign hit_next = (r_state == S_10) && din;

endmodule : sync_detect
`default_nettype wire

// File: rtl/serial_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_ctrl
// Brief    : Serial frame receiver. Hunts for sync 1,0,1, shifts PAYLOAD_W
//            payload bits (MSB first), optionally checks even parity, and
//            hands good frames to a one-entry valid/ready output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_ctrl
  import serial_frame_ctrl_pkg::*;
#(
  parameter int PAYLOAD_W = 8,
  parameter int PARITY_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din,
  output logic [PAYLOAD_W-1:0] frame_data,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 parity_err,
  output logic                 overflow,
  output logic                 busy
);

  localparam int             CNT_W    = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAYLOAD_W - 1);

  fsm_state_t           r_state;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [PAYLOAD_W-1:0] r_shift;

  logic [PAYLOAD_W-1:0] w_shift_nxt;
  logic                 w_hit;
  logic                 w_hit_next;
  logic                 w_go;
  logic                 w_last;
  logic                 w_xfer;
  logic                 w_par_ok;
  logic                 w_good;
  logic                 w_bad;
  logic [PAYLOAD_W-1:0] w_data;

  // Sync search runs only in HUNT; any other state keeps it at its start
  sync_detect u_sync (
    .clk      (clk),
    .reset    (reset),
    .clr      (r_state != HUNT),
    .din      (din),
    .hit      (w_hit),
    .hit_next (w_hit_next)
  );

  // Shift register input: current sample enters at the LSB end
  if (PAYLOAD_W > 1) begin : g_shift_wide
    assign w_shift_nxt = {r_shift[PAYLOAD_W-2:0], din};
  end else begin : g_shift_narrow
    assign w_shift_nxt = din;
  end

  // w_hit also accepts a match already registered in the detector; that
  // cannot normally happen in HUNT but keeps the decode self-consistent
  assign w_go     = (r_state == HUNT) && (w_hit_next || w_hit);
  assign w_last   = (r_bit_cnt == LAST_BIT);
  assign w_xfer   = frame_valid && frame_ready;
  assign w_par_ok = ~(^r_shift ^ din);
  assign busy     = (r_state == RECV) || (r_state == PAR);

  // Frame completion decode: good/bad outcome and the payload to buffer
  always_comb begin
    w_good = 1'b0;
    w_bad  = 1'b0;
    w_data = r_shift;
    if ((r_state == RECV) && w_last && (PARITY_EN == 0)) begin
      w_good = 1'b1;
      w_data = w_shift_nxt;
    end
    if (r_state == PAR) begin
      w_good = w_par_ok;
      w_bad  = ~w_par_ok;
    end
  end

  // Frame FSM with registered buffer and pulse outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HUNT;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      overflow   <= 1'b0;

      if (w_xfer) begin
        frame_valid <= 1'b0;
      end

      case (r_state)
        HUNT: begin
          if (w_go) begin
            r_state   <= RECV;
            r_bit_cnt <= '0;
          end
        end
        RECV: begin
          r_shift   <= w_shift_nxt;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_last) begin
            r_bit_cnt <= '0;
            r_state   <= (PARITY_EN != 0) ? PAR : HUNT;
          end
        end
        PAR: begin
          r_state   <= HUNT;
          r_bit_cnt <= '0;
        end
        default: begin
          r_state   <= HUNT;
          r_bit_cnt <= '0;
        end
      endcase

      // A good frame loads if the buffer is empty or drains on this edge
      if (w_good) begin
        if (!frame_valid || w_xfer) begin
          frame_data  <= w_data;
          frame_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end

      if (w_bad) begin
        parity_err <= 1'b1;
      end
    end
  end

endmodule : serial_frame_ctrl
`default_nettype wire

// File: tb/tb_serial_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_ctrl
// Brief    : Self-checking bench for serial_frame_ctrl. Per-cycle vector table
//            for the 8-bit/parity instance, hand sequence for 4-bit/no-parity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: PAYLOAD_W=8, PARITY_EN=1
  logic       a_rst, a_din, a_rdy;
  logic [7:0] a_data;
  logic       a_valid, a_perr, a_ovf, a_busy;

  serial_frame_ctrl #(.PAYLOAD_W(8), .PARITY_EN(1)) u_dut_a (
    .clk         (clk),
    .reset       (a_rst),
    .din         (a_din),
    .frame_data  (a_data),
    .frame_valid (a_valid),
    .frame_ready (a_rdy),
    .parity_err  (a_perr),
    .overflow    (a_ovf),
    .busy        (a_busy)
  );

  // Instance B: PAYLOAD_W=4, PARITY_EN=0
  logic       b_rst, b_din, b_rdy;
  logic [3:0] b_data;
  logic       b_valid, b_perr, b_ovf, b_busy;

  serial_frame_ctrl #(.PAYLOAD_W(4), .PARITY_EN(0)) u_dut_b (
    .clk         (clk),
    .reset       (b_rst),
    .din         (b_din),
    .frame_data  (b_data),
    .frame_valid (b_valid),
    .frame_ready (b_rdy),
    .parity_err  (b_perr),
    .overflow    (b_ovf),
    .busy        (b_busy)
  );

  typedef struct {
    logic       din;
    logic       rdy;
    logic       rst;
    logic       ev;
    logic [7:0] ed;
    logic       pe;
    logic       ov;
    logic       bz;
  } vec_t;

  vec_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // One table row: inputs for the next edge, outputs expected after it
  task automatic vec(input logic din, input logic rdy, input logic rst,
                     input logic ev, input logic [7:0] ed,
                     input logic pe, input logic ov, input logic bz);
    vec_t v;
    v.din = din; v.rdy = rdy; v.rst = rst; v.ev = ev;
    v.ed  = ed;  v.pe  = pe;  v.ov  = ov;  v.bz = bz;
    q.push_back(v);
  endtask

  // Sync 1,0,1 plus 8 payload bits MSB first; buffer expected to hold ev/ed.
  // busy rises on the final sync edge and stays high through the last payload bit.
  task automatic body(input logic [7:0] pl, input logic rdy,
                      input logic ev, input logic [7:0] ed);
    vec(1'b1, rdy, 1'b0, ev, ed, 1'b0, 1'b0, 1'b0);
    vec(1'b0, rdy, 1'b0, ev, ed, 1'b0, 1'b0, 1'b0);
    vec(1'b1, rdy, 1'b0, ev, ed, 1'b0, 1'b0, 1'b1);
    for (int k = 7; k >= 0; k--) begin
      vec(pl[k], rdy, 1'b0, ev, ed, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    a_rst = 1'b1; a_din = 1'b0; a_rdy = 1'b0;
    b_rst = 1'b1; b_din = 1'b0; b_rdy = 1'b0;

    // ---- table for instance A ----------------------------------------------
    // Reset state (din high must not advance anything)
    vec(1, 0, 1, 0, 8'h00, 0, 0, 0);
    vec(1, 1, 1, 0, 8'h00, 0, 0, 0);
    vec(0, 1, 0, 0, 8'h00, 0, 0, 0);
    vec(0, 1, 0, 0, 8'h00, 0, 0, 0);
    // Good frame 0xA5, parity 0, consumer ready: valid for one cycle
    body(8'hA5, 1, 0, 8'h00);
    vec(0, 1, 0, 1, 8'hA5, 0, 0, 0);
    vec(0, 1, 0, 0, 8'hA5, 0, 0, 0);
    vec(0, 1, 0, 0, 8'hA5, 0, 0, 0);
    // Same frame with bad parity: pulse only, no load, back to HUNT
    body(8'hA5, 1, 0, 8'hA5);
    vec(1, 1, 0, 0, 8'hA5, 1, 0, 0);
    vec(0, 1, 0, 0, 8'hA5, 0, 0, 0);
    // Back-to-back 0xA5 then 0x3C with consumer stalled: overflow once
    body(8'hA5, 0, 0, 8'hA5);
    vec(0, 0, 0, 1, 8'hA5, 0, 0, 0);
    body(8'h3C, 0, 1, 8'hA5);
    vec(0, 0, 0, 1, 8'hA5, 0, 1, 0);
    vec(0, 0, 0, 1, 8'hA5, 0, 0, 0);
    vec(0, 1, 0, 0, 8'hA5, 0, 0, 0);
    // Buffer holds 0x11; ready only on the completion edge of 0x22
    body(8'h11, 0, 0, 8'hA5);
    vec(0, 0, 0, 1, 8'h11, 0, 0, 0);
    body(8'h22, 0, 1, 8'h11);
    vec(0, 1, 0, 1, 8'h22, 0, 0, 0);
    vec(0, 1, 0, 0, 8'h22, 0, 0, 0);
    // Park an unconsumed frame, then overlapping sync 1,0,1,0,1 and reset mid-RECV
    body(8'hA5, 0, 0, 8'h22);
    vec(0, 0, 0, 1, 8'hA5, 0, 0, 0);
    vec(1, 0, 0, 1, 8'hA5, 0, 0, 0);
    vec(0, 0, 0, 1, 8'hA5, 0, 0, 0);
    vec(1, 0, 0, 1, 8'hA5, 0, 0, 1);   // RECV entered at third bit
    vec(0, 0, 0, 1, 8'hA5, 0, 0, 1);   // payload bit 1
    vec(1, 0, 0, 1, 8'hA5, 0, 0, 1);   // payload bit 2
    vec(0, 0, 0, 1, 8'hA5, 0, 0, 1);   // payload bit 3
    vec(1, 0, 1, 0, 8'h00, 0, 0, 0);   // reset: buffer discarded, HUNT
    vec(0, 0, 0, 0, 8'h00, 0, 0, 0);
    body(8'h3C, 0, 0, 8'h00);
    vec(0, 0, 0, 1, 8'h3C, 0, 0, 0);
    vec(0, 1, 0, 0, 8'h3C, 0, 0, 0);
    // Reset on the parity edge of a bad-parity frame: no pulse at all
    body(8'hA5, 0, 0, 8'h3C);
    vec(1, 0, 1, 0, 8'h00, 0, 0, 0);
    vec(0, 0, 0, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      a_din = q[i].din;
      a_rdy = q[i].rdy;
      a_rst = q[i].rst;
      @(posedge clk);
      #1;
      check("A.frame_valid", i, {7'd0, a_valid}, {7'd0, q[i].ev});
      check("A.frame_data",  i, a_data,          q[i].ed);
      check("A.parity_err",  i, {7'd0, a_perr},  {7'd0, q[i].pe});
      check("A.overflow",    i, {7'd0, a_ovf},   {7'd0, q[i].ov});
      check("A.busy",        i, {7'd0, a_busy},  {7'd0, q[i].bz});
    end

    // ---- hand sequence for instance B (4-bit payload, no parity) ------------
    begin
      logic [6:0] b_bits;
      logic [6:0] b_exp_busy;
      logic [6:0] b_exp_valid;
      b_bits      = 7'b1011100;   // din in order, MSB first
      b_exp_busy  = 7'b0011110;
      b_exp_valid = 7'b0000001;

      @(negedge clk);
      b_rst = 1'b1; b_din = 1'b1; b_rdy = 1'b0;
      @(posedge clk);
      #1;
      check("B.reset_valid", 0, {7'd0, b_valid}, 8'd0);
      check("B.reset_busy",  0, {7'd0, b_busy},  8'd0);
      check("B.reset_data",  0, {4'd0, b_data},  8'd0);

      for (int j = 6; j >= 0; j--) begin
        @(negedge clk);
        b_rst = 1'b0;
        b_din = b_bits[j];
        @(posedge clk);
        #1;
        check("B.busy",        6 - j, {7'd0, b_busy},  {7'd0, b_exp_busy[j]});
        check("B.frame_valid", 6 - j, {7'd0, b_valid}, {7'd0, b_exp_valid[j]});
        check("B.parity_err",  6 - j, {7'd0, b_perr},  8'd0);
        check("B.overflow",    6 - j, {7'd0, b_ovf},   8'd0);
      end
      check("B.frame_data", 7, {4'd0, b_data}, 8'h0C);

      // Consumer takes the frame
      @(negedge clk);
      b_din = 1'b0;
      b_rdy = 1'b1;
      @(posedge clk);
      #1;
      check("B.valid_after_xfer", 8, {7'd0, b_valid}, 8'd0);
      check("B.data_after_xfer",  8, {4'd0, b_data},  8'h0C);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_frame_ctrl
`default_nettype wire
